// File: rtl/onehot_decoder.sv
// Binary-to-one-hot decoder with a zero-latency combinational path and a
// registered path that captures the decode whenever in_valid is high.
//
// Parameters:
//   INPUT_WIDTH    width of the binary index (1..16)
//   OUTPUT_WIDTH   width of the one-hot vector (1..2**INPUT_WIDTH)
//   OUT_ACTIVE_LOW 1 inverts both one-hot outputs (active bit reads 0)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (registered path only)
//   binary_in    index to decode
//   in_valid     qualifies binary_in for the registered path
//   one_hot_out  combinational decode of binary_in
//   range_err    combinational flag, binary_in >= OUTPUT_WIDTH
//   one_hot_q    registered decode, loaded when in_valid=1
//   range_err_q  registered range_err, loaded with one_hot_q
//   out_valid    one cycle after every accepted in_valid
module onehot_decoder #(
  parameter int unsigned INPUT_WIDTH    = 2,
  parameter int unsigned OUTPUT_WIDTH   = 1 << INPUT_WIDTH,
  parameter bit          OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INPUT_WIDTH-1:0]  binary_in,
  input  logic                    in_valid,
  output logic [OUTPUT_WIDTH-1:0] one_hot_out,
  output logic [OUTPUT_WIDTH-1:0] one_hot_q,
  output logic                    out_valid,
  output logic                    range_err,
  output logic                    range_err_q
);

  localparam int unsigned FULL_RANGE = 1 << INPUT_WIDTH;

  // Inactive pattern of the output vector; XOR with it applies the polarity.
  localparam logic [OUTPUT_WIDTH-1:0] IDLE_VEC = {OUTPUT_WIDTH{OUT_ACTIVE_LOW}};

  logic [OUTPUT_WIDTH-1:0] dec_raw;
  logic [OUTPUT_WIDTH-1:0] onehot_d, onehot_q;
  logic                    rerr_d, rerr_q;
  logic                    ovld_d, ovld_q;

  // Active-high decode; out-of-range indices match no bit and leave all zeros.
  always_comb begin
    dec_raw = '0;
    for (int unsigned k = 0; k < OUTPUT_WIDTH; k++) begin
      dec_raw[k] = (32'(binary_in) == k);
    end
  end

  // A full-range decoder can never see an out-of-range index.
  if (OUTPUT_WIDTH >= FULL_RANGE) begin : g_full_range
    assign range_err = 1'b0;
  end else begin : g_partial_range
    assign range_err = (32'(binary_in) >= OUTPUT_WIDTH);
  end

  assign one_hot_out = dec_raw ^ IDLE_VEC;

  // Capture only on in_valid so an undriven index while idle cannot leak in.
  always_comb begin
    onehot_d = onehot_q;
    rerr_d   = rerr_q;
    ovld_d   = in_valid;
    if (in_valid) begin
      onehot_d = one_hot_out;
      rerr_d   = range_err;
    end
  end

  // Registered path state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q <= IDLE_VEC;
      rerr_q   <= 1'b0;
      ovld_q   <= 1'b0;
    end else begin
      onehot_q <= onehot_d;
      rerr_q   <= rerr_d;
      ovld_q   <= ovld_d;
    end
  end

  assign one_hot_q   = onehot_q;
  assign range_err_q = rerr_q;
  assign out_valid   = ovld_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed bench for onehot_decoder: three instances cover the default
// configuration, a partial-range decoder (3-bit index, 5 outputs) and the
// inverted-polarity variant. Inputs change on the falling edge; registered
// outputs are checked at the next falling edge.
module tb_onehot_decoder;

  logic clk;
  logic rst_n;

  logic [1:0] a_bin;
  logic       a_vld;
  logic [3:0] a_oh, a_q;
  logic       a_ov, a_err, a_errq;

  logic [2:0] b_bin;
  logic       b_vld;
  logic [4:0] b_oh, b_q;
  logic       b_ov, b_err, b_errq;

  logic [1:0] c_bin;
  logic       c_vld;
  logic [3:0] c_oh, c_q;
  logic       c_ov, c_err, c_errq;

  int total = 0;
  int bad   = 0;

  onehot_decoder u_a (
    .clk(clk), .rst_n(rst_n), .binary_in(a_bin), .in_valid(a_vld),
    .one_hot_out(a_oh), .one_hot_q(a_q), .out_valid(a_ov),
    .range_err(a_err), .range_err_q(a_errq)
  );

  onehot_decoder #(.INPUT_WIDTH(3), .OUTPUT_WIDTH(5)) u_b (
    .clk(clk), .rst_n(rst_n), .binary_in(b_bin), .in_valid(b_vld),
    .one_hot_out(b_oh), .one_hot_q(b_q), .out_valid(b_ov),
    .range_err(b_err), .range_err_q(b_errq)
  );

  onehot_decoder #(.OUT_ACTIVE_LOW(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .binary_in(c_bin), .in_valid(c_vld),
    .one_hot_out(c_oh), .one_hot_q(c_q), .out_valid(c_ov),
    .range_err(c_err), .range_err_q(c_errq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_v;

    rst_n = 1'b0;
    a_bin = '0; a_vld = 1'b0;
    b_bin = '0; b_vld = 1'b0;
    c_bin = '0; c_vld = 1'b0;

    // Reset values after edges with rst_n low.
    repeat (2) @(negedge clk);
    check("rst_a_q",    32'(a_q),    32'h0);
    check("rst_a_ov",   32'(a_ov),   32'h0);
    check("rst_a_errq", 32'(a_errq), 32'h0);
    check("rst_b_q",    32'(b_q),    32'h0);
    check("rst_b_errq", 32'(b_errq), 32'h0);
    check("rst_c_q",    32'(c_q),    32'hF);
    check("rst_c_ov",   32'(c_ov),   32'h0);

    // Exhaustive combinational sweep, done while reset is held.
    for (int v = 0; v < 8; v++) begin
      a_bin = 2'(v);
      b_bin = 3'(v);
      c_bin = 2'(v);
      #2;
      if (v < 4) begin
        exp_v = 32'h1 << v;
        check($sformatf("sweep_a_oh_%0d", v), 32'(a_oh), exp_v);
        check($sformatf("sweep_a_err_%0d", v), 32'(a_err), 32'h0);
        check($sformatf("sweep_a_pop_%0d", v), 32'($countones(a_oh) <= 1), 32'h1);
        exp_v = ~(32'h1 << v) & 32'hF;
        check($sformatf("sweep_c_oh_%0d", v), 32'(c_oh), exp_v);
        check($sformatf("sweep_c_err_%0d", v), 32'(c_err), 32'h0);
        check($sformatf("sweep_c_pop_%0d", v), 32'($countones(~c_oh) <= 1), 32'h1);
      end
      exp_v = (v < 5) ? (32'h1 << v) : 32'h0;
      check($sformatf("sweep_b_oh_%0d", v), 32'(b_oh), exp_v);
      check($sformatf("sweep_b_err_%0d", v), 32'(b_err), (v >= 5) ? 32'h1 : 32'h0);
      check($sformatf("sweep_b_pop_%0d", v), 32'($countones(b_oh) <= 1), 32'h1);
    end

    // Registered path: one capture on each instance.
    @(negedge clk);
    rst_n = 1'b1;
    a_bin = 2'd2; a_vld = 1'b1;
    b_bin = 3'd6; b_vld = 1'b1;
    c_bin = 2'd1; c_vld = 1'b1;
    #1;
    check("b6_oh",  32'(b_oh),  32'h0);
    check("b6_err", 32'(b_err), 32'h1);
    check("c1_oh",  32'(c_oh),  32'hD);

    @(negedge clk);
    check("a2_q",    32'(a_q),    32'h4);
    check("a2_ov",   32'(a_ov),   32'h1);
    check("b6_q",    32'(b_q),    32'h0);
    check("b6_errq", 32'(b_errq), 32'h1);
    check("b6_ov",   32'(b_ov),   32'h1);
    check("c1_q",    32'(c_q),    32'hD);
    check("c1_ov",   32'(c_ov),   32'h1);
    a_vld = 1'b0; a_bin = 'x;
    b_bin = 3'd4;
    c_vld = 1'b0;

    @(negedge clk);
    check("a_hold_q",  32'(a_q),    32'h4);
    check("a_hold_ov", 32'(a_ov),   32'h0);
    check("b4_q",      32'(b_q),    32'h10);
    check("b4_errq",   32'(b_errq), 32'h0);
    check("c_hold_q",  32'(c_q),    32'hD);
    check("c_hold_ov", 32'(c_ov),   32'h0);
    b_vld = 1'b0;

    @(negedge clk);
    check("a_xhold_q", 32'(a_q),  32'h4);
    check("b_idle_ov", 32'(b_ov), 32'h0);

    // Back-to-back stream 0,3,1 then reset between edges.
    a_bin = 2'd0; a_vld = 1'b1;
    @(negedge clk);
    check("s0_q",  32'(a_q),  32'h1);
    check("s0_ov", 32'(a_ov), 32'h1);
    a_bin = 2'd3;
    @(negedge clk);
    check("s3_q",  32'(a_q),  32'h8);
    check("s3_ov", 32'(a_ov), 32'h1);
    a_bin = 2'd1;
    @(negedge clk);
    check("s1_q",  32'(a_q),  32'h2);
    check("s1_ov", 32'(a_ov), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a_q",    32'(a_q),    32'h0);
    check("mid_rst_a_ov",   32'(a_ov),   32'h0);
    check("mid_rst_a_errq", 32'(a_errq), 32'h0);
    check("mid_rst_b_errq", 32'(b_errq), 32'h0);
    check("mid_rst_c_q",    32'(c_q),    32'hF);
    check("mid_rst_a_oh",   32'(a_oh),   32'h2);

    // First capture after reset release waits for in_valid.
    @(negedge clk);
    rst_n = 1'b1;
    a_vld = 1'b0; a_bin = 2'd3;
    @(negedge clk);
    check("post_rst_idle_q",  32'(a_q),  32'h0);
    check("post_rst_idle_ov", 32'(a_ov), 32'h0);
    a_vld = 1'b1;
    @(negedge clk);
    check("post_rst_cap_q",  32'(a_q),  32'h8);
    check("post_rst_cap_ov", 32'(a_ov), 32'h1);
    a_vld = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
